// File: rtl/icache_pkg.sv
// Shared configuration, FSM state type and address-field helpers for the
// direct-mapped instruction cache.
package icache_pkg;

   localparam int CFG_NUM_LINES  = 64;
   localparam int CFG_LINE_WORDS = 4;
   localparam int CFG_ADDR_W     = 32;

   localparam int OFF_W = $clog2(CFG_LINE_WORDS);
   localparam int IDX_W = $clog2(CFG_NUM_LINES);
   localparam int TAG_W = CFG_ADDR_W - OFF_W - IDX_W - 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RESP,
      S_REQ,
      S_WAIT,
      S_GAP
   } state_t;

   // Word offset inside the line (byte offset bits [1:0] are dropped).
   function automatic logic [OFF_W-1:0] addr_off(input logic [CFG_ADDR_W-1:0] a);
      return a[OFF_W+1:2];
   endfunction

   // Line index directly above the word offset.
   function automatic logic [IDX_W-1:0] addr_idx(input logic [CFG_ADDR_W-1:0] a);
      return a[IDX_W+OFF_W+1:OFF_W+2];
   endfunction

   // Everything above the index is tag.
   function automatic logic [TAG_W-1:0] addr_tag(input logic [CFG_ADDR_W-1:0] a);
      return a[CFG_ADDR_W-1:CFG_ADDR_W-TAG_W];
   endfunction

endpackage

// File: rtl/icache_1wa_array.sv
// Valid/tag/data storage for the direct-mapped cache. Reads are
// combinational by index so a hit can be registered in the lookup cycle;
// all writes land on the clock edge.
module icache_1wa_array
   import icache_pkg::*;
#(
   parameter int NUM_LINES  = CFG_NUM_LINES,
   parameter int LINE_WORDS = CFG_LINE_WORDS
) (
   input  logic             clk,
   input  logic             resetn,
   // lookup
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [OFF_W-1:0] rd_off,
   output logic             rd_valid,
   output logic [TAG_W-1:0] rd_tag,
   output logic [31:0]      rd_data,
   // refill word write
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [OFF_W-1:0] wr_off,
   input  logic [31:0]      wr_data,
   // line completion: set valid and tag
   input  logic             fill_en,
   input  logic [IDX_W-1:0] fill_idx,
   input  logic [TAG_W-1:0] fill_tag,
   // drop the resident line when a refill starts
   input  logic             inval_en,
   input  logic [IDX_W-1:0] inval_idx
);

   logic [NUM_LINES-1:0] valid_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [31:0]          data_q [NUM_LINES*LINE_WORDS];

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_data  = data_q[{rd_idx, rd_off}];

   // Valid bits: cleared on reset so a half-refilled line can never hit.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_q <= '0;
      end else begin
         if (inval_en) valid_q[inval_idx] <= 1'b0;
         if (fill_en)  valid_q[fill_idx]  <= 1'b1;
      end
   end

   // Tag store, written once the last beat of a line has arrived.
   always_ff @(posedge clk) begin
      if (fill_en) tag_q[fill_idx] <= fill_tag;
   end

   // Data store, written one word per refill beat.
   always_ff @(posedge clk) begin
      if (wr_en) data_q[{wr_idx, wr_off}] <= wr_data;
   end

endmodule

// File: rtl/icache_1wa.sv
// Direct-mapped read-only instruction cache for the picorv32 fetch port.
// Hits answer one cycle after the request is seen; misses refill the whole
// line in order word 0..LINE_WORDS-1 over a single-outstanding port, then
// answer from the captured word.
module icache_1wa
   import icache_pkg::*;
#(
   parameter int NUM_LINES  = CFG_NUM_LINES,
   parameter int LINE_WORDS = CFG_LINE_WORDS,
   parameter int ADDR_W     = CFG_ADDR_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              proc_valid,
   output logic              proc_ready,
   input  logic [ADDR_W-1:0] proc_addr,
   output logic [31:0]       proc_rdata,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic [31:0]       mem_req_rdata
);

   localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

   state_t           state;
   logic [TAG_W-1:0] lat_tag;
   logic [IDX_W-1:0] lat_idx;
   logic [OFF_W-1:0] lat_off;
   logic [OFF_W-1:0] cnt;
   logic [OFF_W-1:0] cnt_nxt;

   logic [TAG_W-1:0] p_tag;
   logic [IDX_W-1:0] p_idx;
   logic [OFF_W-1:0] p_off;

   logic             rd_valid;
   logic [TAG_W-1:0] rd_tag;
   logic [31:0]      rd_data;
   logic             hit;
   logic             beat_done;
   logic             line_done;
   logic             miss_start;

   assign p_tag = addr_tag(proc_addr);
   assign p_idx = addr_idx(proc_addr);
   assign p_off = addr_off(proc_addr);

   assign hit        = rd_valid && (rd_tag == p_tag);
   assign cnt_nxt    = cnt + OFF_W'(1);
   assign beat_done  = resetn && (state == S_REQ || state == S_WAIT) && mem_req_ready;
   assign line_done  = resetn && (state == S_GAP) && (cnt == LAST_BEAT);
   assign miss_start = resetn && (state == S_IDLE) && proc_valid && !hit;

   icache_1wa_array #(
      .NUM_LINES  (NUM_LINES),
      .LINE_WORDS (LINE_WORDS)
   ) u_array (
      .clk       (clk),
      .resetn    (resetn),
      .rd_idx    (p_idx),
      .rd_off    (p_off),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (rd_data),
      .wr_en     (beat_done),
      .wr_idx    (lat_idx),
      .wr_off    (cnt),
      .wr_data   (mem_req_rdata),
      .fill_en   (line_done),
      .fill_idx  (lat_idx),
      .fill_tag  (lat_tag),
      .inval_en  (miss_start),
      .inval_idx (p_idx)
   );

   // Lookup / refill FSM with registered handshake outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= S_IDLE;
         proc_ready    <= 1'b0;
         proc_rdata    <= '0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         lat_tag       <= '0;
         lat_idx       <= '0;
         lat_off       <= '0;
         cnt           <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (proc_valid) begin
                  lat_tag <= p_tag;
                  lat_idx <= p_idx;
                  lat_off <= p_off;
                  if (hit) begin
                     proc_rdata <= rd_data;
                     proc_ready <= 1'b1;
                     state      <= S_RESP;
                  end else begin
                     cnt           <= '0;
                     mem_req_valid <= 1'b1;
                     mem_req_addr  <= {p_tag, p_idx, {OFF_W{1'b0}}, 2'b00};
                     state         <= S_REQ;
                  end
               end
            end
            S_RESP: begin
               proc_ready <= 1'b0;
               state      <= S_IDLE;
            end
            S_REQ, S_WAIT: begin
               if (mem_req_ready) begin
                  // the requested word is forwarded as it streams past
                  if (cnt == lat_off) proc_rdata <= mem_req_rdata;
                  mem_req_valid <= 1'b0;
                  state         <= S_GAP;
               end else begin
                  state <= S_WAIT;
               end
            end
            S_GAP: begin
               if (cnt == LAST_BEAT) begin
                  proc_ready <= 1'b1;
                  state      <= S_RESP;
               end else begin
                  cnt           <= cnt_nxt;
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= {lat_tag, lat_idx, cnt_nxt, 2'b00};
                  state         <= S_REQ;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache_1wa.sv
// Scoreboard bench for icache_1wa: expected fetch data and refill addresses
// are queued when a fetch is issued and popped when the DUT produces them.
module tb_icache_1wa;

   logic        clk = 1'b0;
   logic        resetn;
   logic        proc_valid;
   logic        proc_ready;
   logic [31:0] proc_addr;
   logic [31:0] proc_rdata;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic [31:0] mem_req_rdata;

   int vec_cnt = 0;
   int err_cnt = 0;

   logic [31:0] exp_data_q[$];
   logic [31:0] exp_addr_q[$];
   int          mem_lat  = 0;
   int          beats    = 0;
   int          pulses   = 0;
   int          answered = 0;

   // tag model of the cache: 64 lines, 4 words per line
   logic        mv[64];
   logic [21:0] mt[64];

   always #5 clk = ~clk;

   icache_1wa dut (
      .clk           (clk),
      .resetn        (resetn),
      .proc_valid    (proc_valid),
      .proc_ready    (proc_ready),
      .proc_addr     (proc_addr),
      .proc_rdata    (proc_rdata),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_addr  (mem_req_addr),
      .mem_req_rdata (mem_req_rdata)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h13579BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 64; i++) begin
         mv[i] = 1'b0;
         mt[i] = '0;
      end
   endtask

   // memory responder: checks refill order and address hold, answers after mem_lat cycles
   initial begin : responder
      int          wcnt;
      logic [31:0] cur;
      wcnt = 0;
      cur  = '0;
      mem_req_ready = 1'b0;
      mem_req_rdata = '0;
      forever begin
         @(negedge clk);
         if (resetn === 1'b1 && mem_req_valid === 1'b1) begin
            if (wcnt == 0) begin
               cur = mem_req_addr;
               if (exp_addr_q.size() == 0) chk("req_unexpected", 32'd1, 32'd0);
               else                         chk("req_addr", mem_req_addr, exp_addr_q.pop_front());
            end else begin
               chk("req_addr_hold", mem_req_addr, cur);
            end
            if (wcnt == mem_lat) begin
               mem_req_ready = 1'b1;
               mem_req_rdata = mem_word(mem_req_addr);
               beats++;
            end
            wcnt++;
         end else begin
            mem_req_ready = 1'b0;
            wcnt = 0;
         end
      end
   end

   // response monitor: every proc_ready pops one expected word
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (proc_ready === 1'b1) begin
            pulses++;
            if (exp_data_q.size() == 0) chk("resp_unexpected", 32'd1, 32'd0);
            else                         chk("rdata", proc_rdata, exp_data_q.pop_front());
         end
      end
   end

   task automatic fetch(input logic [31:0] a, input int lat);
      int          idx;
      logic [21:0] tg;
      bit          hit;
      bit          got;
      int          b0;
      int          cyc;
      idx = int'(a[9:4]);
      tg  = a[31:10];
      hit = mv[idx] && (mt[idx] == tg);
      chk("resp_once", 32'(pulses), 32'(answered));
      mem_lat = lat;
      exp_data_q.push_back(mem_word({a[31:2], 2'b00}));
      if (!hit)
         for (int i = 0; i < 4; i++) exp_addr_q.push_back({a[31:4], 4'h0} + 32'(4 * i));
      b0  = beats;
      cyc = 0;
      got = 0;
      proc_addr  = a;
      proc_valid = 1'b1;
      while (!got && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (proc_ready === 1'b1) got = 1;
      end
      proc_valid = 1'b0;
      if (!got) begin
         chk("timeout", 32'd0, 32'd1);
         exp_data_q.delete();
         exp_addr_q.delete();
      end else begin
         answered++;
         if (hit) begin
            chk("hit_lat", 32'(cyc), 32'd1);
            chk("hit_beats", 32'(beats - b0), 32'd0);
         end else begin
            chk("miss_lat", 32'(cyc), 32'(1 + 4 * (lat + 2)));
            chk("miss_beats", 32'(beats - b0), 32'd4);
            chk("refill_left", 32'(exp_addr_q.size()), 32'd0);
            mv[idx] = 1'b1;
            mt[idx] = tg;
         end
      end
      @(negedge clk);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int cyc;
      int b0;
      resetn     = 1'b0;
      proc_valid = 1'b0;
      proc_addr  = '0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("rst_proc_ready", 32'(proc_ready), 32'd0);
      chk("rst_proc_rdata", proc_rdata, 32'd0);
      chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_mem_addr", mem_req_addr, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // cold miss, then hit in the same line, then same-index conflicts
      fetch(32'h0000_0000, 1);
      fetch(32'h0000_0008, 0);
      fetch(32'h0000_0400, 0);
      fetch(32'h0000_0000, 1);
      // slow memory: address must hold across wait states
      fetch(32'h0000_0014, 5);
      // back-to-back hits across a whole line
      fetch(32'h0000_0000, 0);
      fetch(32'h0000_0004, 0);
      fetch(32'h0000_0008, 0);
      fetch(32'h0000_000C, 0);
      fetch(32'h0000_0016, 0);

      // reset in the middle of beat 2 of a refill
      chk("resp_once", 32'(pulses), 32'(answered));
      mem_lat = 2;
      exp_data_q.push_back(mem_word(32'h0000_0020));
      for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'h0000_0020 + 32'(4 * i));
      b0  = beats;
      cyc = 0;
      proc_addr  = 32'h0000_0020;
      proc_valid = 1'b1;
      while (!(beats - b0 == 2 && mem_req_valid === 1'b1 && mem_req_ready === 1'b0) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 200) chk("timeout_beat2", 32'd0, 32'd1);
      @(negedge clk);
      resetn     = 1'b0;
      proc_valid = 1'b0;
      exp_data_q.delete();
      exp_addr_q.delete();
      model_clear();
      repeat (2) @(negedge clk);
      chk("midrst_mem_valid", 32'(mem_req_valid), 32'd0);
      chk("midrst_proc_ready", 32'(proc_ready), 32'd0);
      chk("midrst_mem_addr", mem_req_addr, 32'd0);
      resetn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("idle_mem_valid", 32'(mem_req_valid), 32'd0);
      end
      chk("no_resp_after_rst", 32'(pulses), 32'(answered));
      fetch(32'h0000_0020, 0);
      fetch(32'h0000_0024, 0);

      // random fetches over a small window to mix hits, misses and evictions
      for (int i = 0; i < 25; i++)
         fetch({21'd0, 9'($urandom_range(0, 511)), 2'($urandom_range(0, 3))}, int'($urandom_range(0, 2)));

      repeat (3) @(negedge clk);
      chk("resp_once_final", 32'(pulses), 32'(answered));
      chk("scoreboard_empty", 32'(exp_data_q.size() + exp_addr_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
